data_mem_mmio: RTL and testbench

//  Data-memory stage directly downstream of the single-cycle Datapath.
//  - Consumes ALUResult (address), datatwo (store data) and the memory control signals.
//  - Returns ReadData for the MemtoReg path.
//  - Contains a byte-addressable word RAM with byte/half/word loads and stores.
//  - Contains a memory-mapped I/O page: GPIO plus a 32-bit compare timer with interrupt.

---
 rtl/data_mem_mmio.sv | 155 +++++++++++++++
 tb/tb_data_mem_mmio.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// Data-memory stage: byte-addressable word RAM plus a memory-mapped page holding
// GPIO and a 32-bit compare timer with interrupt.
module data_mem_mmio #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [15:0] MMIO_PAGE  = 16'hFFFF,
  parameter int unsigned GPIO_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       datatwo,
  output logic [31:0]       ReadData,
  output logic              MisalignFault,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              timer_irq
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  localparam logic [15:0] OffGpioOut = 16'h0000;
  localparam logic [15:0] OffGpioIn  = 16'h0004;
  localparam logic [15:0] OffCount   = 16'h0008;
  localparam logic [15:0] OffCmp     = 16'h000C;
  localparam logic [15:0] OffCtrl    = 16'h0010;

  logic [31:0]           mem [Words];
  logic [ADDR_WIDTH-1:0] idx;
  logic [15:0]           off;
  logic                  is_mmio, fault;
  logic                  ram_we, mmio_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata, ram_word, ram_shift, ram_ld, mmio_ld;

  logic [GPIO_W-1:0] gpio_out_q, sync1_q, sync2_q;
  logic [31:0]       count_q, count_d, cmp_q;
  logic              en_q, flag_q, flag_d, ar_q;
  logic              wr_gpio, wr_count, wr_cmp, wr_ctrl, match_set;

  assign is_mmio = (ALUResult[31:16] == MMIO_PAGE);
  assign off     = ALUResult[15:0];
  assign idx     = ALUResult[ADDR_WIDTH+1:2];

  always_comb begin
    fault = 1'b0;
    case (MemSize)
      2'b00:   fault = 1'b0;
      2'b01:   fault = ALUResult[0];
      2'b10:   fault = (ALUResult[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
    // MMIO registers only accept whole-word accesses.
    if (is_mmio && MemSize != 2'b10) fault = 1'b1;
  end

  assign MisalignFault = fault;
  assign ram_we  = MemWrite && !fault && !is_mmio;
  assign mmio_we = MemWrite && !fault && is_mmio;

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = datatwo;
    case (MemSize)
      2'b00: begin
        ram_be    = 4'b0001 << ALUResult[1:0];
        ram_wdata = {4{datatwo[7:0]}};
      end
      2'b01: begin
        ram_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{datatwo[15:0]}};
      end
      default: ram_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    ram_word  = mem[idx];
    ram_shift = ram_word >> {ALUResult[1:0], 3'b000};
    case (MemSize)
      2'b00:   ram_ld = {{24{MemSigned & ram_shift[7]}}, ram_shift[7:0]};
      2'b01:   ram_ld = {{16{MemSigned & ram_shift[15]}}, ram_shift[15:0]};
      default: ram_ld = ram_word;
    endcase
  end

  always_comb begin
    mmio_ld = '0;
    case (off)
      OffGpioOut: mmio_ld[GPIO_W-1:0] = gpio_out_q;
      OffGpioIn:  mmio_ld[GPIO_W-1:0] = sync2_q;
      OffCount:   mmio_ld = count_q;
      OffCmp:     mmio_ld = cmp_q;
      OffCtrl:    mmio_ld[2:0] = {ar_q, flag_q, en_q};
      default:    mmio_ld = '0;
    endcase
  end

  assign ReadData = (!MemRead || fault) ? 32'h0 : (is_mmio ? mmio_ld : ram_ld);

  assign wr_gpio  = mmio_we && (off == OffGpioOut);
  assign wr_count = mmio_we && (off == OffCount);
  assign wr_cmp   = mmio_we && (off == OffCmp);
  assign wr_ctrl  = mmio_we && (off == OffCtrl);

  always_comb begin
    match_set = en_q && (count_q == cmp_q);
    count_d   = count_q;
    if (en_q) count_d = (match_set && ar_q) ? 32'h0 : count_q + 32'd1;
    if (wr_count) count_d = datatwo;
    flag_d = flag_q;
    if (wr_ctrl && datatwo[1]) flag_d = 1'b0;
    // A hardware match wins over a same-cycle software clear.
    if (match_set) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
      en_q       <= 1'b0;
      flag_q     <= 1'b0;
      ar_q       <= 1'b0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      count_q <= count_d;
      flag_q  <= flag_d;
      if (wr_gpio) gpio_out_q <= datatwo[GPIO_W-1:0];
      if (wr_cmp)  cmp_q      <= datatwo;
      if (wr_ctrl) begin
        en_q <= datatwo[0];
        ar_q <= datatwo[2];
      end
    end
  end

  assign gpio_out  = gpio_out_q;
  assign timer_irq = flag_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus randomized RAM and
// timer traffic compared against a byte-array / register-level reference model.
module tb_data_mem_mmio;

  localparam logic [31:0] AGpioOut = 32'hFFFF0000;
  localparam logic [31:0] AGpioIn  = 32'hFFFF0004;
  localparam logic [31:0] ACount   = 32'hFFFF0008;
  localparam logic [31:0] ACmp     = 32'hFFFF000C;
  localparam logic [31:0] ACtrl    = 32'hFFFF0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead, MemSigned, MisalignFault, timer_irq;
  logic [1:0]  MemSize;
  logic [31:0] ALUResult, datatwo, ReadData;
  logic [15:0] gpio_out, gpio_in;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_byte  [1024];
  bit         m_valid [1024];
  logic [31:0] m_count, m_cmp;
  logic        m_en, m_flag, m_ar;

  data_mem_mmio dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemSize      (MemSize),
    .MemSigned    (MemSigned),
    .ALUResult    (ALUResult),
    .datatwo      (datatwo),
    .ReadData     (ReadData),
    .MisalignFault(MisalignFault),
    .gpio_out     (gpio_out),
    .gpio_in      (gpio_in),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  function automatic bit f_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (a[31:16] == 16'hFFFF && sz != 2'd2) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic we, input logic re, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    MemWrite = we; MemRead = re; MemSize = sz; MemSigned = sg; ALUResult = a; datatwo = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, sz, 1'b0, a, d);
    tick();
  endtask

  task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      output logic [31:0] rd);
    drive(1'b0, 1'b1, sz, sg, a, 32'h0);
    rd = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #3;
    checks++; if (gpio_out !== 16'h0) begin errors++; $display("FAIL rst_gpio: got %h exp 0", gpio_out); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", timer_irq); end
    @(posedge clk); #1; reset = 1'b1;
    load(2, 0, ACount, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_count: got %h exp 0", rd); end
    load(2, 0, ACtrl, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h exp 0", rd); end
    load(2, 0, ACmp, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_cmp: got %h exp 0", rd); end
  endtask

  task automatic test_ram_directed();
    logic [31:0] rd;
    store(2, 32'h40, 32'h11223344);
    load(2, 0, 32'h40, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw40: got %h exp 11223344", rd); end
    load(0, 1, 32'h43, rd);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb43: got %h exp 00000011", rd); end
    load(0, 0, 32'h40, rd);
    checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL lbu40: got %h exp 00000044", rd); end
    store(0, 32'h41, 32'h80);
    load(1, 1, 32'h40, rd);
    checks++; if (rd !== 32'hFFFF8044) begin errors++; $display("FAIL lh40: got %h exp FFFF8044", rd); end
    load(1, 0, 32'h40, rd);
    checks++; if (rd !== 32'h00008044) begin errors++; $display("FAIL lhu40: got %h exp 00008044", rd); end
    load(2, 0, 32'h40, rd);
    checks++; if (rd !== 32'h11228044) begin errors++; $display("FAIL lw40b: got %h exp 11228044", rd); end
    load(2, 0, 32'h12340440, rd);
    checks++; if (rd !== 32'h11228044) begin errors++; $display("FAIL alias: got %h exp 11228044", rd); end
    drive(1'b0, 1'b0, 2, 0, 32'h40, 32'h0);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL noread: got %h exp 0", ReadData); end
  endtask

  task automatic test_gpio();
    logic [31:0] rd;
    store(2, AGpioOut, 32'h0000A5A5);
    checks++; if (gpio_out !== 16'hA5A5) begin errors++; $display("FAIL gpio_out: got %h exp A5A5", gpio_out); end
    load(2, 0, AGpioOut, rd);
    checks++; if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL gpio_rb: got %h exp 0000A5A5", rd); end
    gpio_in = 16'h1234;
    load(2, 0, AGpioIn, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL gpin0: got %h exp 0", rd); end
    tick();
    load(2, 0, AGpioIn, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL gpin1: got %h exp 0", rd); end
    tick();
    load(2, 0, AGpioIn, rd);
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL gpin2: got %h exp 1234", rd); end
    load(2, 0, 32'hFFFF0014, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped: got %h exp 0", rd); end
  endtask

  task automatic test_fault();
    logic [31:0] rd;
    load(2, 0, 32'h42, rd);
    checks++; if (MisalignFault !== 1'b1) begin errors++; $display("FAIL lw42_flt: got %b exp 1", MisalignFault); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lw42_rd: got %h exp 0", rd); end
    store(2, 32'h42, 32'hDEADBEEF);
    load(2, 0, 32'h40, rd);
    checks++; if (rd !== 32'h11228044) begin errors++; $display("FAIL sw42: got %h exp 11228044", rd); end
    drive(1'b1, 1'b0, 1, 0, AGpioOut, 32'h0000BEEF);
    checks++; if (MisalignFault !== 1'b1) begin errors++; $display("FAIL sh_mmio_flt: got %b exp 1", MisalignFault); end
    tick();
    checks++; if (gpio_out !== 16'hA5A5) begin errors++; $display("FAIL sh_mmio: got %h exp A5A5", gpio_out); end
    load(3, 0, 32'h40, rd);
    checks++; if (MisalignFault !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL size3: got flt=%b rd=%h exp flt=1 rd=0", MisalignFault, rd);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] rd;
    drive(1'b1, 1'b1, 2, 0, 32'h40, 32'hCAFEF00D);
    checks++; if (ReadData !== 32'h11228044) begin errors++; $display("FAIL rdw_old: got %h exp 11228044", ReadData); end
    tick();
    load(2, 0, 32'h40, rd);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rdw_new: got %h exp CAFEF00D", rd); end
  endtask

  task automatic test_timer();
    logic [31:0] rd;
    store(2, ACmp, 32'd3);
    store(2, ACtrl, 32'h5);
    store(2, ACount, 32'd0);
    for (int k = 0; k < 4; k++) begin
      load(2, 0, ACount, rd);
      checks++; if (rd !== k) begin errors++; $display("FAIL tmr_cnt%0d: got %h exp %h", k, rd, k); end
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_irq%0d: got %b exp 0", k, timer_irq); end
      tick();
    end
    load(2, 0, ACount, rd);
    checks++; if (rd !== 32'h0 || timer_irq !== 1'b1) begin
      errors++; $display("FAIL tmr_match: got cnt=%h irq=%b exp cnt=0 irq=1", rd, timer_irq);
    end
    tick();
    store(2, ACtrl, 32'h7);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b exp 0", timer_irq); end
    tick();
    load(2, 0, ACount, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL tmr_pre: got %h exp 3", rd); end
    store(2, ACtrl, 32'h7);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL w1c_match: got %b exp 1", timer_irq); end
  endtask

  task automatic test_timer_random();
    logic [31:0] rd, d, a, exp;
    logic        set;
    int          op;
    store(2, ACtrl, 32'h0);
    store(2, ACtrl, 32'h2);
    m_cmp = $urandom_range(0, 6);
    store(2, ACmp, m_cmp);
    store(2, ACount, 32'h0);
    m_count = 0; m_en = 0; m_flag = 0; m_ar = 0;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      d  = (op == 0) ? $urandom_range(0, 8) : $urandom_range(0, 7);
      a  = (op == 0 || op == 2) ? ACount : ACtrl;
      drive(op < 2, 1'b1, 2, 0, a, d);
      exp = (a == ACount) ? m_count : {29'b0, m_ar, m_flag, m_en};
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL trnd_rd%0d: got %h exp %h", i, ReadData, exp); end
      checks++; if (timer_irq !== m_flag) begin errors++; $display("FAIL trnd_irq%0d: got %b exp %b", i, timer_irq, m_flag); end
      set = m_en && (m_count == m_cmp);
      if (m_en) m_count = (set && m_ar) ? 32'h0 : m_count + 1;
      if (op == 0) m_count = d;
      if (op == 1 && d[1]) m_flag = 1'b0;
      if (set) m_flag = 1'b1;
      if (op == 1) begin m_en = d[0]; m_ar = d[2]; end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    store(2, ACtrl, 32'h0);
    store(2, ACmp, 32'd1000);
    store(2, AGpioOut, 32'h0000BEEF);
    store(2, ACount, 32'd0);
    store(2, ACtrl, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    load(2, 0, ACount, rd);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL mid_cnt: got %h exp 5", rd); end
    reset = 1'b0;
    #1;
    checks++; if (gpio_out !== 16'h0 || timer_irq !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got gpio=%h irq=%b exp 0 0", gpio_out, timer_irq);
    end
    @(posedge clk); #1; reset = 1'b1;
    load(2, 0, ACount, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_count: got %h exp 0", rd); end
    load(2, 0, ACtrl, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_ctrl: got %h exp 0", rd); end
    for (int i = 0; i < 3; i++) tick();
    load(2, 0, ACount, rd);
    checks++; if (rd !== 32'h0 || timer_irq !== 1'b0) begin
      errors++; $display("FAIL mid_stopped: got cnt=%h irq=%b exp 0 0", rd, timer_irq);
    end
  endtask

  task automatic test_ram_random();
    logic [31:0] rd, a, d, exp, hi;
    logic [1:0]  sz;
    logic        sg, flt, allv;
    int          n, ix;
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      hi = $urandom_range(0, 16'hFFFE);
      a  = (hi << 16) | $urandom_range(0, 63);
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      flt = f_fault(sz, a);
      n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      if ($urandom_range(0, 1) == 0) begin
        drive(1'b1, 1'b0, sz, 1'b0, a, d);
        checks++; if (MisalignFault !== flt) begin errors++; $display("FAIL rnd_sflt%0d: got %b exp %b", i, MisalignFault, flt); end
        tick();
        if (!flt) begin
          for (int b = 0; b < n; b++) begin
            ix = (a + b) % 1024;
            m_byte[ix] = 8'(d >> (8 * b));
            m_valid[ix] = 1'b1;
          end
        end
      end else begin
        load(sz, sg, a, rd);
        checks++; if (MisalignFault !== flt) begin errors++; $display("FAIL rnd_lflt%0d: got %b exp %b", i, MisalignFault, flt); end
        exp = 0; allv = 1'b1;
        if (!flt) begin
          for (int b = 0; b < n; b++) begin
            ix = (a + b) % 1024;
            allv &= m_valid[ix];
            exp |= 32'(m_byte[ix]) << (8 * b);
          end
          if (sg && n == 1 && exp[7])  exp = exp - 32'h100;
          if (sg && n == 2 && exp[15]) exp = exp - 32'h10000;
        end
        if (allv) begin
          checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_ld%0d: got %h exp %h", i, rd, exp); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; MemSize = 2'b10; MemSigned = 1'b0;
    ALUResult = 32'h0; datatwo = 32'h0; gpio_in = 16'h0;
    test_reset();
    test_ram_directed();
    test_gpio();
    test_fault();
    test_read_during_write();
    test_timer();
    test_timer_random();
    test_reset_mid();
    test_ram_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
